// File: rtl/r5p_csr_pkg.sv
// Shared CSR field types used across the core.
package r5p_csr_pkg;

    localparam int CSR_XLEN = 32;

    // mcause layout: interrupt flag in the MSB, exception/interrupt code below it.
    typedef struct packed {
        logic                intr;
        logic [CSR_XLEN-2:0] code;
    } csr_mcause_t;

endpackage

// File: rtl/r5p_pkg.sv
// Trap-controller states and machine interrupt codes.
package r5p_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        TRAP     = 2'd2,
        REDIRECT = 2'd3
    } trap_state_e;

    // mcause interrupt codes
    localparam logic [4:0] IRQ_CODE_MEI = 5'd11;
    localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
    localparam logic [4:0] IRQ_CODE_MSI = 5'd3;

    // Bit positions inside the {MEI, MTI, MSI} vectors
    localparam int IRQ_BIT_MEI = 2;
    localparam int IRQ_BIT_MTI = 1;
    localparam int IRQ_BIT_MSI = 0;

endpackage

// File: rtl/r5p_sync.sv
// Multi-flop synchronizer for one asynchronous level input.
module r5p_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw level in at bit 0; the oldest sample leaves from the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= (r_sync << 1) | SYNC_STAGES'(d_i);
    end

    assign q_o = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/r5p_trap_ctl.sv
// Machine-mode trap controller: synchronizes interrupt lines, arbitrates
// interrupts against synchronous exceptions and sequences trap/redirect.
module r5p_trap_ctl
    import r5p_pkg::*;
    import r5p_csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_ext_i,
    input  logic            irq_tim_i,
    input  logic            irq_sft_i,
    input  logic            mstatus_mie_i,
    input  logic [2:0]      mie_i,
    input  logic            exc_vld_i,
    input  logic [4:0]      exc_cause_i,
    input  logic            retire_i,
    output logic [2:0]      mip_o,
    output logic            stall_o,
    output logic            trap_o,
    output logic [XLEN-1:0] cause_o,
    output logic            flush_o
);

    logic [2:0]  w_irq;
    logic [2:0]  w_mip;
    logic [2:0]  w_elig;
    logic [4:0]  w_irq_code;
    csr_mcause_t w_irq_cause;
    csr_mcause_t w_exc_cause;
    csr_mcause_t w_cause_nxt;
    logic        w_cause_ld;
    trap_state_e r_state;
    trap_state_e w_state_nxt;
    csr_mcause_t r_cause;

    assign w_irq = {irq_ext_i, irq_tim_i, irq_sft_i};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        r5p_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (w_irq[gi]),
            .q_o (w_mip[gi])
        );
    end

    assign mip_o  = w_mip;
    assign w_elig = w_mip & mie_i & {3{mstatus_mie_i}};

    // Fixed-priority pick among eligible interrupts (MEI > MSI > MTI) and cause encodings.
    always_comb begin
        w_irq_code = IRQ_CODE_MTI;
        if (w_elig[IRQ_BIT_MEI])      w_irq_code = IRQ_CODE_MEI;
        else if (w_elig[IRQ_BIT_MSI]) w_irq_code = IRQ_CODE_MSI;
        w_irq_cause.intr = 1'b1;
        w_irq_cause.code = (CSR_XLEN-1)'(w_irq_code);
        w_exc_cause.intr = 1'b0;
        w_exc_cause.code = (CSR_XLEN-1)'(exc_cause_i);
    end

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, cause capture and per-state outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_ld  = 1'b0;
        w_cause_nxt = w_exc_cause;
        stall_o     = 1'b0;
        trap_o      = 1'b0;
        flush_o     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (exc_vld_i) begin
                    w_state_nxt = TRAP;
                    w_cause_ld  = 1'b1;
                end else if (|w_elig) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                stall_o = 1'b1;
                if (exc_vld_i) begin
                    w_state_nxt = TRAP;
                    w_cause_ld  = 1'b1;
                end else if (retire_i) begin
                    // The request may have dropped while draining; re-check at the boundary.
                    if (|w_elig) begin
                        w_state_nxt = TRAP;
                        w_cause_ld  = 1'b1;
                        w_cause_nxt = w_irq_cause;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            TRAP: begin
                stall_o     = 1'b1;
                trap_o      = 1'b1;
                w_state_nxt = REDIRECT;
            end
            REDIRECT: begin
                stall_o     = 1'b1;
                flush_o     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Cause register loads only on entry to TRAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_cause <= '0;
        else if (w_cause_ld) r_cause <= w_cause_nxt;
    end

    assign cause_o = {r_cause.intr, (XLEN-1)'(r_cause.code)};

endmodule

// File: tb/tb_r5p_trap_ctl.sv
// Self-checking bench for r5p_trap_ctl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_r5p_trap_ctl;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_ext, irq_tim, irq_sft;
    logic        gmie;
    logic [2:0]  mie;
    logic        exc;
    logic [4:0]  ec;
    logic        retire;
    logic [2:0]  mip;
    logic        stall, trap, flush;
    logic [31:0] cause;

    int n_chk  = 0;
    int n_fail = 0;

    r5p_trap_ctl #(.XLEN(32), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_ext_i     (irq_ext),
        .irq_tim_i     (irq_tim),
        .irq_sft_i     (irq_sft),
        .mstatus_mie_i (gmie),
        .mie_i         (mie),
        .exc_vld_i     (exc),
        .exc_cause_i   (ec),
        .retire_i      (retire),
        .mip_o         (mip),
        .stall_o       (stall),
        .trap_o        (trap),
        .cause_o       (cause),
        .flush_o       (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  irq;
        logic        exc;
        logic [4:0]  ec;
        logic        ret;
        logic        stall;
        logic        trap;
        logic        flush;
        logic [2:0]  mip;
        logic [31:0] cause;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_irq(input logic [2:0] v);
        irq_ext = v[2];
        irq_tim = v[1];
        irq_sft = v[0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_irq(3'b000);
        gmie = 1'b1; mie = 3'b111; exc = 1'b0; ec = '0; retire = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_stall(input string name);
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (stall === 1'b1) ok = 1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Behavioural model: mip is the irq level delayed by SYNC edges; a trap
    // is a two-cycle burst (trap, then flush) scheduled by m_busy.
    bit          m_drain;
    int          m_busy;
    logic [31:0] m_cause;
    logic [2:0]  m_pipe[$];

    task automatic model_reset();
        m_drain = 0; m_busy = 0; m_cause = '0;
        m_pipe = {};
        for (int i = 0; i < SYNC; i++) m_pipe.push_back(3'b000);
    endtask

    function automatic logic [31:0] irq_cause(input logic [2:0] el);
        if (el[2])      return 32'h8000_000B;
        else if (el[0]) return 32'h8000_0003;
        else            return 32'h8000_0007;
    endfunction

    task automatic model_edge(input logic [2:0] irq);
        logic [2:0] el;
        el = m_pipe[0] & mie & {3{gmie}};
        if (m_busy > 0) begin
            m_busy--;
        end else if (exc) begin
            m_busy = 2; m_drain = 0; m_cause = {27'd0, ec};
        end else if (m_drain) begin
            if (retire) begin
                m_drain = 0;
                if (|el) begin
                    m_busy  = 2;
                    m_cause = irq_cause(el);
                end
            end
        end else if (|el) begin
            m_drain = 1;
        end
        void'(m_pipe.pop_front());
        m_pipe.push_back(irq);
    endtask

    initial begin
        // irq,  exc, ec,  ret | stall trap flush mip  cause (checked when trap)
        tbl[0]  = '{3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[1]  = '{3'b000, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0002};
        tbl[2]  = '{3'b000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0};
        tbl[3]  = '{3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[4]  = '{3'b110, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[5]  = '{3'b110, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'h0};
        tbl[6]  = '{3'b110, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 32'h0};
        tbl[7]  = '{3'b110, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b110, 32'h8000_000B};
        tbl[8]  = '{3'b000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 32'h0};
        tbl[9]  = '{3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[10] = '{3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[11] = '{3'b001, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[12] = '{3'b001, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0};
        tbl[13] = '{3'b001, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0005};
        tbl[14] = '{3'b001, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0};
        tbl[15] = '{3'b000, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0};
        tbl[16] = '{3'b000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[17] = '{3'b000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};

        // Reset state
        rst = 1'b1;
        set_irq(3'b111);
        gmie = 1'b1; mie = 3'b111; exc = 1'b1; ec = 5'd9; retire = 1'b1;
        tick(); tick();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_trap",  32'(trap),  32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_mip",   32'(mip),   32'd0);
        chk("rst_cause", cause,      32'd0);

        // Directed vector table
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_irq(tbl[i].irq);
            exc = tbl[i].exc; ec = tbl[i].ec; retire = tbl[i].ret;
            tick();
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
            chk($sformatf("vec%0d_trap", i),  32'(trap),  32'(tbl[i].trap));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].flush));
            chk($sformatf("vec%0d_mip", i),   32'(mip),   32'(tbl[i].mip));
            if (tbl[i].trap) chk($sformatf("vec%0d_cause", i), cause, tbl[i].cause);
        end
        exc = 1'b0; retire = 1'b0;

        // Globally disabled software interrupt: pending but never taken
        begin
            bit seen = 0;
            do_reset();
            gmie = 1'b0;
            set_irq(3'b001);
            for (int i = 0; i < 20; i++) begin
                tick();
                if (stall !== 1'b0 || trap !== 1'b0) seen = 1;
            end
            chk("gmie0_mip", 32'(mip), 32'd1);
            chk("gmie0_no_stall_trap", 32'(seen), 32'd0);
        end

        // Timer request dropped while draining, then exception during drain
        begin
            bit seen = 0;
            do_reset();
            set_irq(3'b010);
            wait_stall("mti_enter_drain");
            set_irq(3'b000);
            tick(); tick(); tick();
            chk("drain_hold_stall", 32'(stall), 32'd1);
            chk("drain_mip_clear",  32'(mip),   32'd0);
            retire = 1'b1;
            tick();
            retire = 1'b0;
            chk("drain_abort_stall", 32'(stall), 32'd0);
            for (int i = 0; i < 3; i++) begin
                tick();
                if (trap !== 1'b0 || stall !== 1'b0) seen = 1;
            end
            chk("drain_abort_no_trap", 32'(seen), 32'd0);
            set_irq(3'b010);
            wait_stall("mti_reenter_drain");
            exc = 1'b1; ec = 5'd3;
            tick();
            exc = 1'b0;
            set_irq(3'b000);
            chk("drain_exc_trap",  32'(trap), 32'd1);
            chk("drain_exc_cause", cause,     32'h0000_0003);
            tick();
            chk("drain_exc_flush", 32'(flush), 32'd1);
        end

        // Reset asserted during TRAP
        begin
            bit seen = 0;
            do_reset();
            exc = 1'b1; ec = 5'd4;
            tick();
            exc = 1'b0;
            chk("pre_rst_trap", 32'(trap), 32'd1);
            #2 rst = 1'b1;
            #1;
            chk("midrst_stall", 32'(stall), 32'd0);
            chk("midrst_trap",  32'(trap),  32'd0);
            chk("midrst_flush", 32'(flush), 32'd0);
            chk("midrst_cause", cause,      32'd0);
            tick();
            rst = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (flush !== 1'b0 || trap !== 1'b0) seen = 1;
            end
            chk("postrst_no_pulse", 32'(seen), 32'd0);
        end

        // Randomized run against the behavioural model
        do_reset();
        model_reset();
        begin
            logic [2:0] irq = 3'b000;
            for (int i = 0; i < 800; i++) begin
                for (int b = 0; b < 3; b++)
                    if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
                set_irq(irq);
                gmie = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 19) == 0) mie = 3'($urandom_range(0, 7));
                exc    = ($urandom_range(0, 11) == 0);
                ec     = 5'($urandom_range(0, 31));
                retire = ($urandom_range(0, 3) == 0);
                model_edge(irq);
                tick();
                chk("rnd_stall", 32'(stall), 32'(m_drain || m_busy > 0));
                chk("rnd_trap",  32'(trap),  32'(m_busy == 2));
                chk("rnd_flush", 32'(flush), 32'(m_busy == 1));
                chk("rnd_mip",   32'(mip),   32'(m_pipe[0]));
                chk("rnd_cause", cause,      m_cause);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
